dmem_io: RTL and testbench
==========================

Name: dmem_io

Overview:
- Data-side memory subsystem directly downstream of the pipelined core's MEM stage.
- Consumes the core's `ena_wr`, `ena_rd`, `alu_out_ext` (address) and `dataram_wr`. Returns `dataram_rd` combinationally in the same cycle; the core captures it into WB at the next edge.
- Contains a word-addressed data RAM plus a memory-mapped I/O page: GPIO out/in and a 32-bit compare timer with an interrupt flag.

Parameters:
- RAM_WORDS, 1024, number of 32-bit data RAM words (power of two).
- GPIO_W, 16, width of the GPIO input and output buses.
- IO_BASE, 32'h1000_0000, base address of the I/O page (4 KB).

Ports:
- CLOCK  input  1  system clock, all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- ena_wr  input  1  store strobe from the MEM stage.
- ena_rd  input  1  load strobe from the MEM stage.
- alu_out_ext  input  32  byte address from the MEM stage.
- dataram_wr  input  32  store data.
- dataram_rd  output  32  load data, combinational.
- gpio_in  input  GPIO_W  asynchronous external inputs.
- gpio_out  output  GPIO_W  registered output port.
- timer_irq  output  1  level interrupt request.

Behaviour:
- One clock (CLOCK); reset RST is synchronous and active-high. All registers clear on the RST edge. RAM contents are not reset.
- Reset values: gpio_out = 0, timer_irq = 0, CNT = CMP = CTRL = 0, GPIO sync flops = 0. dataram_rd follows the read path below, so it is 0 whenever ena_rd = 0.
- Word access only. Address bits [1:0] are ignored; no byte/half lanes.
- Decode:
  - RAM when addr[31:28] == 0: index addr[log2(RAM_WORDS)+1:2]; higher bits alias (wrap-around).
  - IO when addr[31:12] == IO_BASE[31:12].
  - Anything else is unmapped: reads return 0, writes are dropped.
- IO offsets (addr[11:0]):
  - 0x000 GPIO_OUT, RW.
  - 0x004 GPIO_IN, RO, zero-extended, 2-flop synchronised.
  - 0x008 TIMER_CNT, RW.
  - 0x00C TIMER_CMP, RW.
  - 0x010 TIMER_CTRL: bit0 EN, bit1 FLAG (write-1-clears), bit2 AUTORELOAD, bit3 IRQ_EN; other bits read 0.
  - Other IO offsets read 0; writes are ignored.
- Read path: dataram_rd = ena_rd ? decoded data : 0, with zero cycles of latency. The RAM read is asynchronous.
- Write path: takes effect at the rising edge where ena_wr = 1. A read of the same address in the same cycle returns the old value.
- ena_wr and ena_rd both high is legal; the read returns the pre-write value.
- GPIO_IN reflects a pin change 2 cycles after it is sampled.
- Timer (EN = 1), evaluated each edge:
  - If CNT == CMP: FLAG <= 1, and CNT <= AUTORELOAD ? 0 : CNT+1.
  - Otherwise: CNT <= CNT+1, modulo 2^32 (0xFFFF_FFFF wraps to 0).
- With EN = 0, CNT holds and no compare events occur.
- Simultaneous events:
  - A CPU write to TIMER_CNT beats the increment/reload.
  - A compare hit in the same cycle as a FLAG W1C leaves FLAG = 1 (set wins).
  - A CPU write to TIMER_CMP is used for compare from the next cycle.
- timer_irq = FLAG & IRQ_EN, registered-free: it is combinational from the state flops.
- Reset mid-operation: the timer stops and clears and the IRQ drops on the same edge. Loads during RST still return RAM data; IO loads return 0.

Decomposition:
- Package dmem_io_pkg:
  - IO offset localparams (OFF_GPIO_OUT, OFF_GPIO_IN, OFF_TCNT, OFF_TCMP, OFF_TCTRL).
  - CTRL bit index constants.
  - Region-decode enum typedef (REG_RAM, REG_IO, REG_NONE).
- Sub-module io_timer:
  - Holds CNT/CMP/CTRL.
  - Inputs: write strobes and data.
  - Outputs: read values and timer_irq.
- The top level holds the RAM array, decode, GPIO flops and the read mux.

Test Plan:
- Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 next cycle -> dataram_rd = 0xDEADBEEF. Load with ena_rd = 0 -> 0.
- RAM_WORDS = 1024: store 0x1234 to 0x0000_1000 -> a load of 0x0000_0000 returns 0x1234 (alias). Load of 0x2000_0000 -> 0.
- Write gpio_out via 0x1000_0000 = 0xA5A5 -> gpio_out = 0xA5A5 after the edge. Set gpio_in = 0x00FF -> the GPIO_IN load reads 0x00FF from the 2nd cycle on, 0 before.
- CMP = 5, CTRL = 0b1101 (EN, AUTORELOAD, IRQ_EN) -> FLAG and timer_irq rise on the edge where CNT = 5, and CNT returns to 0. W1C with CTRL = 0b1111 -> irq drops; the next hit comes 6 cycles later.
- CNT written to 0xFFFF_FFFE with EN = 1 and CMP = 0x10 -> reads ...FFFF, then 0, with no flag. A write of CNT = 7 during counting overrides the increment.
- Assert RST while the timer runs and FLAG = 1 -> next cycle CNT = CTRL = 0, timer_irq = 0, gpio_out = 0, and earlier RAM data is still readable.

Source files
------------

// File: rtl/dmem_io_pkg.sv
// dmem_io_pkg: shared definitions for the data-side memory subsystem.
//   - I/O page register offsets (byte offsets within the 4 KB page)
//   - TIMER_CTRL bit positions
//   - address region type and the region decoder used by the top level
package dmem_io_pkg;

  localparam logic [11:0] OFF_GPIO_OUT = 12'h000;
  localparam logic [11:0] OFF_GPIO_IN  = 12'h004;
  localparam logic [11:0] OFF_TCNT     = 12'h008;
  localparam logic [11:0] OFF_TCMP     = 12'h00C;
  localparam logic [11:0] OFF_TCTRL    = 12'h010;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_FLAG   = 1;
  localparam int unsigned CTRL_AR     = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_NONE
  } region_t;

  // RAM occupies the whole bottom 256 MB (aliased); the I/O page is matched
  // on its upper 20 address bits. RAM wins if the two ever overlap.
  function automatic region_t decode_region(input logic [31:0] addr,
                                            input logic [19:0] io_page);
    if (addr[31:28] == 4'h0) begin
      return REG_RAM;
    end else if (addr[31:12] == io_page) begin
      return REG_IO;
    end else begin
      return REG_NONE;
    end
  endfunction

endpackage

// File: rtl/dmem_io_timer.sv
// io_timer: 32-bit compare timer with sticky flag and level interrupt.
//   clk, rst      : clock and synchronous active-high reset
//   cnt_we        : CPU write to TIMER_CNT (beats increment/reload)
//   cmp_we        : CPU write to TIMER_CMP (compare uses it from next cycle)
//   ctrl_we       : CPU write to TIMER_CTRL (FLAG bit is write-1-to-clear)
//   wdata         : write data for all three registers
//   cnt, cmp, ctrl: read-back values (ctrl bits above 3 read as zero)
//   irq           : FLAG & IRQ_EN, combinational from state flops
module io_timer
  import dmem_io_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        ctrl_we,
  input  logic [31:0] wdata,
  output logic [31:0] cnt,
  output logic [31:0] cmp,
  output logic [31:0] ctrl,
  output logic        irq
);

  logic en;
  logic flag;
  logic autoreload;
  logic irq_en;

  logic        hit;
  logic [31:0] cnt_next;
  logic        flag_next;

  always_comb begin
    hit       = en && (cnt == cmp);
    cnt_next  = cnt;
    flag_next = flag;

    if (en) begin
      cnt_next = (hit && autoreload) ? '0 : cnt + 32'd1;
    end
    if (cnt_we) begin
      cnt_next = wdata;
    end

    // A compare hit in the same cycle as a W1C leaves the flag set.
    if (ctrl_we && wdata[CTRL_FLAG]) begin
      flag_next = 1'b0;
    end
    if (hit) begin
      flag_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      cmp        <= '0;
      en         <= 1'b0;
      flag       <= 1'b0;
      autoreload <= 1'b0;
      irq_en     <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      flag <= flag_next;
      if (cmp_we) begin
        cmp <= wdata;
      end
      if (ctrl_we) begin
        en         <= wdata[CTRL_EN];
        autoreload <= wdata[CTRL_AR];
        irq_en     <= wdata[CTRL_IRQ_EN];
      end
    end
  end

  always_comb begin
    ctrl              = '0;
    ctrl[CTRL_EN]     = en;
    ctrl[CTRL_FLAG]   = flag;
    ctrl[CTRL_AR]     = autoreload;
    ctrl[CTRL_IRQ_EN] = irq_en;
  end

  assign irq = flag & irq_en;

endmodule

// File: rtl/dmem_io.sv
// dmem_io: data RAM plus memory-mapped I/O page behind the core's MEM stage.
//   CLOCK, RST  : clock and synchronous active-high reset
//   ena_wr      : store strobe; write lands on the rising edge
//   ena_rd      : load strobe; dataram_rd is 0 when low
//   alu_out_ext : byte address (bits [1:0] ignored, word access only)
//   dataram_wr  : store data
//   dataram_rd  : combinational load data (pre-write value on same-cycle RMW)
//   gpio_in     : asynchronous pins, 2-flop synchronised, read at GPIO_IN
//   gpio_out    : registered output port, written at GPIO_OUT
//   timer_irq   : level interrupt from the compare timer
module dmem_io
  import dmem_io_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned GPIO_W    = 16,
  parameter logic [31:0] IO_BASE   = 32'h1000_0000
) (
  input  logic              CLOCK,
  input  logic              RST,
  input  logic              ena_wr,
  input  logic              ena_rd,
  input  logic [31:0]       alu_out_ext,
  input  logic [31:0]       dataram_wr,
  output logic [31:0]       dataram_rd,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  logic [31:0] mem [RAM_WORDS];

  region_t     region;
  logic [AW-1:0] idx;
  logic [11:0] off;

  logic ram_we;
  logic io_we;
  logic gpio_we;
  logic cnt_we;
  logic cmp_we;
  logic ctrl_we;

  logic [GPIO_W-1:0] gpio_sync1;
  logic [GPIO_W-1:0] gpio_sync2;

  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic [31:0] tctrl;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^alu_out_ext[1:0];

  always_comb begin
    region = decode_region(alu_out_ext, IO_BASE[31:12]);
  end

  // Higher RAM address bits are simply not decoded, so the array aliases.
  assign idx = alu_out_ext[AW+1:2];
  assign off = {alu_out_ext[11:2], 2'b00};

  assign ram_we  = ena_wr && (region == REG_RAM);
  assign io_we   = ena_wr && (region == REG_IO);
  assign gpio_we = io_we && (off == OFF_GPIO_OUT);
  assign cnt_we  = io_we && (off == OFF_TCNT);
  assign cmp_we  = io_we && (off == OFF_TCMP);
  assign ctrl_we = io_we && (off == OFF_TCTRL);

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge CLOCK) begin
    if (ram_we) begin
      mem[idx] <= dataram_wr;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      gpio_out   <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
    end else begin
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
      if (gpio_we) begin
        gpio_out <= dataram_wr[GPIO_W-1:0];
      end
    end
  end

  io_timer u_timer (
    .clk     (CLOCK),
    .rst     (RST),
    .cnt_we  (cnt_we),
    .cmp_we  (cmp_we),
    .ctrl_we (ctrl_we),
    .wdata   (dataram_wr),
    .cnt     (tcnt),
    .cmp     (tcmp),
    .ctrl    (tctrl),
    .irq     (timer_irq)
  );

  // IO loads are forced to zero while RST is high; RAM stays readable.
  always_comb begin
    dataram_rd = '0;
    if (ena_rd) begin
      unique case (region)
        REG_RAM: dataram_rd = mem[idx];
        REG_IO: begin
          if (!RST) begin
            case (off)
              OFF_GPIO_OUT: dataram_rd = 32'(gpio_out);
              OFF_GPIO_IN:  dataram_rd = 32'(gpio_sync2);
              OFF_TCNT:     dataram_rd = tcnt;
              OFF_TCMP:     dataram_rd = tcmp;
              OFF_TCTRL:    dataram_rd = tctrl;
              default:      dataram_rd = '0;
            endcase
          end
        end
        default: dataram_rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_io.sv
module tb_dmem_io;

  localparam logic [31:0] A_GOUT  = 32'h1000_0000;
  localparam logic [31:0] A_GIN   = 32'h1000_0004;
  localparam logic [31:0] A_TCNT  = 32'h1000_0008;
  localparam logic [31:0] A_TCMP  = 32'h1000_000C;
  localparam logic [31:0] A_TCTRL = 32'h1000_0010;

  logic        CLOCK = 1'b0;
  logic        RST;
  logic        ena_wr;
  logic        ena_rd;
  logic [31:0] alu_out_ext;
  logic [31:0] dataram_wr;
  logic [31:0] dataram_rd;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        timer_irq;

  int total = 0;
  int bad   = 0;

  dmem_io #(
    .RAM_WORDS (1024),
    .GPIO_W    (16),
    .IO_BASE   (32'h1000_0000)
  ) dut (
    .CLOCK       (CLOCK),
    .RST         (RST),
    .ena_wr      (ena_wr),
    .ena_rd      (ena_rd),
    .alu_out_ext (alu_out_ext),
    .dataram_wr  (dataram_wr),
    .dataram_rd  (dataram_rd),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .timer_irq   (timer_irq)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    alu_out_ext = a;
    dataram_wr  = d;
    ena_wr      = 1'b1;
    tick();
    ena_wr      = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    alu_out_ext = a;
    ena_rd      = 1'b1;
    #1;
    d           = dataram_rd;
    ena_rd      = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RST = 1'b1;
    tick();
    tick();
    total++;
    if (gpio_out !== 16'h0) begin
      bad++; $display("FAIL reset_gpio_out got=%h exp=%h", gpio_out, 16'h0);
    end
    total++;
    if (timer_irq !== 1'b0) begin
      bad++; $display("FAIL reset_irq got=%b exp=0", timer_irq);
    end
    alu_out_ext = 32'h0000_0010;
    #1;
    total++;
    if (dataram_rd !== 32'h0) begin
      bad++; $display("FAIL reset_rd_idle got=%h exp=0", dataram_rd);
    end
    RST = 1'b0;
    rd(A_TCNT, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL reset_cnt got=%h exp=0", d);
    end
    rd(A_TCMP, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL reset_cmp got=%h exp=0", d);
    end
    rd(A_TCTRL, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL reset_ctrl got=%h exp=0", d);
    end
    rd(A_GIN, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL reset_gpio_in got=%h exp=0", d);
    end
    tick();
  endtask

  task automatic test_ram();
    logic [31:0] d;
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, d);
    total++;
    if (d !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL ram_rd got=%h exp=%h", d, 32'hDEAD_BEEF);
    end
    rd(32'h0000_0013, d);
    total++;
    if (d !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL ram_lsb_ignored got=%h exp=%h", d, 32'hDEAD_BEEF);
    end
    alu_out_ext = 32'h0000_0010;
    ena_rd = 1'b0;
    #1;
    total++;
    if (dataram_rd !== 32'h0) begin
      bad++; $display("FAIL ram_rd_disabled got=%h exp=0", dataram_rd);
    end
    wr(32'h0000_1000, 32'h0000_1234);
    rd(32'h0000_0000, d);
    total++;
    if (d !== 32'h0000_1234) begin
      bad++; $display("FAIL ram_alias got=%h exp=%h", d, 32'h0000_1234);
    end
    wr(32'h2000_0000, 32'h5555_5555);
    rd(32'h2000_0000, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL unmapped_rd got=%h exp=0", d);
    end
    rd(32'h0000_0000, d);
    total++;
    if (d !== 32'h0000_1234) begin
      bad++; $display("FAIL unmapped_wr_dropped got=%h exp=%h", d, 32'h0000_1234);
    end
    // read and write same address in the same cycle
    alu_out_ext = 32'h0000_0010;
    dataram_wr  = 32'h1111_1111;
    ena_wr      = 1'b1;
    ena_rd      = 1'b1;
    #1;
    total++;
    if (dataram_rd !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL ram_rmw_old got=%h exp=%h", dataram_rd, 32'hDEAD_BEEF);
    end
    tick();
    ena_wr = 1'b0;
    #1;
    total++;
    if (dataram_rd !== 32'h1111_1111) begin
      bad++; $display("FAIL ram_rmw_new got=%h exp=%h", dataram_rd, 32'h1111_1111);
    end
    ena_rd = 1'b0;
  endtask

  task automatic test_gpio();
    logic [31:0] d;
    wr(A_GOUT, 32'h0000_A5A5);
    total++;
    if (gpio_out !== 16'hA5A5) begin
      bad++; $display("FAIL gpio_out got=%h exp=%h", gpio_out, 16'hA5A5);
    end
    rd(A_GOUT, d);
    total++;
    if (d !== 32'h0000_A5A5) begin
      bad++; $display("FAIL gpio_out_rd got=%h exp=%h", d, 32'h0000_A5A5);
    end
    rd(32'h1000_0020, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL io_hole_rd got=%h exp=0", d);
    end
    gpio_in = 16'h00FF;
    rd(A_GIN, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL gpio_in_c0 got=%h exp=0", d);
    end
    tick();
    rd(A_GIN, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL gpio_in_c1 got=%h exp=0", d);
    end
    tick();
    rd(A_GIN, d);
    total++;
    if (d !== 32'h0000_00FF) begin
      bad++; $display("FAIL gpio_in_c2 got=%h exp=%h", d, 32'h0000_00FF);
    end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    wr(A_TCMP, 32'd5);
    wr(A_TCTRL, 32'b1101);      // counting starts from the following edge
    repeat (5) tick();
    rd(A_TCNT, d);
    total++;
    if (d !== 32'd5) begin
      bad++; $display("FAIL timer_cnt5 got=%h exp=%h", d, 32'd5);
    end
    total++;
    if (timer_irq !== 1'b0) begin
      bad++; $display("FAIL timer_irq_pre got=%b exp=0", timer_irq);
    end
    tick();
    total++;
    if (timer_irq !== 1'b1) begin
      bad++; $display("FAIL timer_irq_hit got=%b exp=1", timer_irq);
    end
    rd(A_TCNT, d);
    total++;
    if (d !== 32'd0) begin
      bad++; $display("FAIL timer_reload got=%h exp=0", d);
    end
    rd(A_TCTRL, d);
    total++;
    if (d !== 32'hF) begin
      bad++; $display("FAIL timer_ctrl_flag got=%h exp=%h", d, 32'hF);
    end
    wr(A_TCTRL, 32'b1111);
    total++;
    if (timer_irq !== 1'b0) begin
      bad++; $display("FAIL timer_w1c got=%b exp=0", timer_irq);
    end
    repeat (4) tick();
    total++;
    if (timer_irq !== 1'b0) begin
      bad++; $display("FAIL timer_irq_early got=%b exp=0", timer_irq);
    end
    tick();
    total++;
    if (timer_irq !== 1'b1) begin
      bad++; $display("FAIL timer_second_hit got=%b exp=1", timer_irq);
    end
    repeat (5) tick();
    rd(A_TCNT, d);
    total++;
    if (d !== 32'd5) begin
      bad++; $display("FAIL timer_cnt5b got=%h exp=%h", d, 32'd5);
    end
    wr(A_TCTRL, 32'b1111);      // W1C on the hit edge
    total++;
    if (timer_irq !== 1'b1) begin
      bad++; $display("FAIL timer_set_wins got=%b exp=1", timer_irq);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    wr(A_TCTRL, 32'b0010);
    wr(A_TCMP, 32'h10);
    wr(A_TCNT, 32'hFFFF_FFFE);
    wr(A_TCTRL, 32'b0001);
    rd(A_TCNT, d);
    total++;
    if (d !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL wrap_c0 got=%h exp=%h", d, 32'hFFFF_FFFE);
    end
    tick();
    rd(A_TCNT, d);
    total++;
    if (d !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL wrap_c1 got=%h exp=%h", d, 32'hFFFF_FFFF);
    end
    tick();
    rd(A_TCNT, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL wrap_c2 got=%h exp=0", d);
    end
    rd(A_TCTRL, d);
    total++;
    if (d !== 32'h1) begin
      bad++; $display("FAIL wrap_noflag got=%h exp=1", d);
    end
    wr(A_TCNT, 32'd7);
    rd(A_TCNT, d);
    total++;
    if (d !== 32'd7) begin
      bad++; $display("FAIL cnt_wr_override got=%h exp=7", d);
    end
    tick();
    rd(A_TCNT, d);
    total++;
    if (d !== 32'd8) begin
      bad++; $display("FAIL cnt_after_wr got=%h exp=8", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(A_TCTRL, 32'b0000);
    wr(A_TCNT, 32'd0);
    wr(A_TCMP, 32'd1);
    wr(A_TCTRL, 32'b1001);
    tick();
    tick();
    total++;
    if (timer_irq !== 1'b1) begin
      bad++; $display("FAIL mid_irq_set got=%b exp=1", timer_irq);
    end
    total++;
    if (gpio_out !== 16'hA5A5) begin
      bad++; $display("FAIL mid_gpio_pre got=%h exp=%h", gpio_out, 16'hA5A5);
    end
    RST = 1'b1;
    tick();
    total++;
    if (timer_irq !== 1'b0) begin
      bad++; $display("FAIL mid_irq_drop got=%b exp=0", timer_irq);
    end
    total++;
    if (gpio_out !== 16'h0) begin
      bad++; $display("FAIL mid_gpio_clr got=%h exp=0", gpio_out);
    end
    rd(32'h0000_0010, d);
    total++;
    if (d !== 32'h1111_1111) begin
      bad++; $display("FAIL mid_ram_kept got=%h exp=%h", d, 32'h1111_1111);
    end
    rd(A_GIN, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL mid_io_in_rst got=%h exp=0", d);
    end
    RST = 1'b0;
    rd(A_TCNT, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL mid_cnt got=%h exp=0", d);
    end
    rd(A_TCTRL, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL mid_ctrl got=%h exp=0", d);
    end
    tick();
    rd(A_TCNT, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL mid_cnt_stopped got=%h exp=0", d);
    end
  endtask

  initial begin
    RST         = 1'b1;
    ena_wr      = 1'b0;
    ena_rd      = 1'b0;
    alu_out_ext = '0;
    dataram_wr  = '0;
    gpio_in     = '0;
    test_reset();
    test_ram();
    test_gpio();
    test_timer();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
